// File: rtl/decode_stage_pipe_pkg.sv
// decode_pkg: op indices, opcode patterns and immediate formats for the LEGv8 decode stage
package decode_pkg;
  typedef enum logic [3:0] {
    OP_ADDI, OP_ADDS, OP_AND, OP_EOR, OP_LSR, OP_LDUR,
    OP_STUR, OP_B, OP_CBZ, OP_RSVD, OP_SUBS, OP_BCOND
  } op_idx_e;
  localparam int NUM_OPS = 12;
  typedef enum logic [2:0] {IMM_I, IMM_R_SH, IMM_D, IMM_B, IMM_CB, IMM_NONE} imm_fmt_e;
  // {mask, match}; B.cond's mask also pins instr[4] low, and the reserved slot never matches
  function automatic logic [63:0] op_pat(op_idx_e o);
    case (o)
      OP_ADDI:  return {32'hFFC0_0000, 32'h9100_0000};
      OP_ADDS:  return {32'hFFE0_0000, 32'hAB00_0000};
      OP_AND:   return {32'hFFE0_0000, 32'h8A00_0000};
      OP_EOR:   return {32'hFFE0_0000, 32'hCA00_0000};
      OP_SUBS:  return {32'hFFE0_0000, 32'hEB00_0000};
      OP_LSR:   return {32'hFFE0_0000, 32'hD340_0000};
      OP_LDUR:  return {32'hFFE0_0000, 32'hF840_0000};
      OP_STUR:  return {32'hFFE0_0000, 32'hF800_0000};
      OP_B:     return {32'hFC00_0000, 32'h1400_0000};
      OP_BCOND: return {32'hFF00_0010, 32'h5400_0000};
      OP_CBZ:   return {32'hFF00_0000, 32'hB400_0000};
      default:  return {32'h0000_0000, 32'h0000_0001};
    endcase
  endfunction
endpackage

// File: rtl/decode_stage_pipe_if.sv
// decode_stage_pipe_if: fetch-side handshake in, decoded bundle out
interface decode_stage_pipe_if import decode_pkg::*; #(
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 64,
  parameter int PC_W    = 64,
  parameter int CNT_W   = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OPS-1:0] out_op;
  logic [4:0]         out_rd;
  logic [4:0]         out_rn;
  logic [4:0]         out_rm;
  logic [DATA_W-1:0]  out_imm;
  logic [3:0]         out_cond;
  logic [PC_W-1:0]    out_pc;
  logic               out_illegal;
  logic [CNT_W-1:0]   illegal_cnt;
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_op, out_rd, out_rn, out_rm, out_imm,
           out_cond, out_pc, out_illegal, illegal_cnt
  );
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_op, out_rd, out_rn, out_rm, out_imm,
           out_cond, out_pc, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/decode_stage_pipe_op_match.sv
// op_match_comb: exact-compare opcode matcher producing a one-hot op vector and immediate format
module op_match_comb import decode_pkg::*; (
  input  logic [31:0]        instr_i,
  output logic [NUM_OPS-1:0] op_o,
  output imm_fmt_e           fmt_o
);
  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    localparam logic [63:0] P = op_pat(op_idx_e'(4'(g)));
    assign op_o[g] = (instr_i & P[63:32]) == P[31:0];
  end
  always_comb
    fmt_o = op_o[OP_ADDI]                   ? IMM_I    :
            op_o[OP_LSR]                    ? IMM_R_SH :
            (op_o[OP_LDUR] | op_o[OP_STUR]) ? IMM_D    :
            op_o[OP_B]                      ? IMM_B    :
            (op_o[OP_BCOND] | op_o[OP_CBZ]) ? IMM_CB   : IMM_NONE;
endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: registered LEGv8 decode stage with valid/ready handshake, flush and
// a saturating illegal-instruction counter.
module decode_stage_pipe import decode_pkg::*; #(
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 64,
  parameter int PC_W    = 64,
  parameter int CNT_W   = 8
) (
  input logic                clk,
  input logic                reset_n,
  decode_stage_pipe_if.slave bus
);
  if (INSTR_W != 32) begin : g_instr_w
    $error("INSTR_W must be 32");
  end
  logic [31:0]        ins;
  logic [NUM_OPS-1:0] op;
  imm_fmt_e           fmt;
  logic               accept, keep, illegal;
  logic               valid_q, valid_d, ill_q;
  logic [NUM_OPS-1:0] op_q;
  logic [4:0]         rd_q, rn_q, rm_q;
  logic [3:0]         cond_q, cond_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [PC_W-1:0]    pc_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  assign ins = bus.in_instr;
  op_match_comb u_match (.instr_i(ins), .op_o(op), .fmt_o(fmt));
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign keep         = accept && !bus.flush;
  assign illegal      = ~|op;
  // branch offsets stay in words; the execute stage does the shift
  always_comb begin
    imm_d   = fmt == IMM_I    ? DATA_W'(ins[21:10]) :
              fmt == IMM_R_SH ? DATA_W'(ins[15:10]) :
              fmt == IMM_D    ? {{(DATA_W-9){ins[20]}}, ins[20:12]} :
              fmt == IMM_B    ? {{(DATA_W-26){ins[25]}}, ins[25:0]} :
              fmt == IMM_CB   ? {{(DATA_W-19){ins[23]}}, ins[23:5]} : '0;
    cond_d  = op[OP_BCOND] ? ins[3:0] : 4'd0;
    valid_d = bus.flush ? 1'b0 : accept ? 1'b1 : valid_q && !bus.out_ready;
    cnt_d   = (keep && illegal && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      imm_q   <= '0;
      cond_q  <= '0;
      pc_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (keep) begin
        op_q   <= op;
        rd_q   <= ins[4:0];
        rn_q   <= ins[9:5];
        rm_q   <= ins[20:16];
        imm_q  <= imm_d;
        cond_q <= cond_d;
        pc_q   <= bus.in_pc;
        ill_q  <= illegal;
      end
    end
  assign bus.out_valid   = valid_q;
  assign bus.out_op      = op_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_rn      = rn_q;
  assign bus.out_rm      = rm_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_cond    = cond_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_illegal = ill_q;
  assign bus.illegal_cnt = cnt_q;
endmodule
